glb_layer_launcher: RTL and testbench
=====================================

Name: glb_layer_launcher

Overview:
- Host-facing stage directly upstream of the accelerator top; it also consumes that top's results.
- Per layer it runs four steps in order:
  - streams ifmap/filter/bias words from the host into the GLB write port;
  - pulses start to the accelerator top and waits for its done;
  - reads the opsum region back out of the GLB;
  - streams the opsum words to the host.
- Owns the GLB ports whenever the accelerator is not running.

Parameters:
- DATA_SIZE, 32, GLB word width (bits).
- ADDR_BITS, 32, GLB byte-address width.
- LEN_BITS, 16, word-count width for load/drain lengths.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  layer descriptor valid.
- cfg_ready  out  1  high only in IDLE.
- cfg_load_base  in  ADDR_BITS  GLB byte address of the first load word.
- cfg_load_len  in  LEN_BITS  number of words to load.
- cfg_drain_base  in  ADDR_BITS  GLB byte address of the opsum region.
- cfg_drain_len  in  LEN_BITS  number of opsum words to drain.
- in_valid  in  1  host load-stream valid.
- in_ready  out  1  host load-stream ready.
- in_data  in  DATA_SIZE  load word.
- out_valid  out  1  drain-stream valid.
- out_ready  in  1  drain-stream ready.
- out_data  out  DATA_SIZE  opsum word.
- glb_we  out  4  byte write enable.
- glb_w_addr  out  ADDR_BITS  byte write address.
- glb_w_data  out  DATA_SIZE  write data.
- glb_re  out  4  read enable.
- glb_r_addr  out  ADDR_BITS  byte read address.
- glb_r_data  in  DATA_SIZE  read data, valid exactly 1 cycle after glb_re != 0.
- glb_own  out  1  1 = launcher drives the GLB ports; 0 = accelerator controller does.
- start  out  1  one-cycle launch pulse to the accelerator.
- done  in  1  accelerator completion.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async on rst low, regardless of current state):
  - state = IDLE;
  - all counters = 0;
  - skid buffer empty;
  - glb_we = 0, glb_re = 0, start = 0, out_valid = 0, in_ready = 0;
  - glb_own = 1, cfg_ready = 1, busy = 0.
- Reset mid-operation abandons the layer; no partial-state recovery.
- IDLE:
  - on cfg_valid && cfg_ready, latch the descriptor and clear the word counters;
  - go to LOAD if load_len != 0, else to RUN.
- LOAD:
  - in_ready = 1;
  - each in_valid && in_ready drives, in the same cycle: glb_we = 4'hF, glb_w_addr = load_base + 4*load_cnt, glb_w_data = in_data;
  - load_cnt increments on each accepted word;
  - after accepting word load_len-1, go to RUN next cycle.
- RUN:
  - glb_own = 0;
  - start = 1 only in the first RUN cycle;
  - wait for done = 1, then go to DRAIN (skip to IDLE if drain_len == 0);
  - done arriving in the start cycle is accepted;
  - done while not in RUN is ignored.
- DRAIN:
  - glb_own = 1;
  - read issue: glb_re = 4'hF, glb_r_addr = drain_base + 4*issue_cnt;
  - a read is issued only when issue_cnt < drain_len AND (skid occupancy + reads in flight) < 2;
  - return data is pushed into the skid buffer the cycle after issue;
  - out_valid = skid not empty, out_data = skid head;
  - pop on out_valid && out_ready;
  - when pop_cnt reaches drain_len, go to IDLE.
  - Sustained out_ready = 1 gives 1 word/cycle after 2 cycles of latency.
  - Simultaneous push and pop is legal when full: occupancy stays at 2.
- Arithmetic and ranges:
  - addresses are computed modulo 2^ADDR_BITS, so wrap-around is silent;
  - lengths are unsigned;
  - cfg_drain_len = 2^LEN_BITS - 1 is legal.
- Invariants:
  - glb_we = 0 outside LOAD;
  - glb_re = 0 outside DRAIN;
  - glb_own = 0 only in RUN.

Decomposition:
- Package glb_launcher_pkg holds:
  - state enum {IDLE, LOAD, RUN, DRAIN};
  - GLB_WORD_BYTES = 4;
  - GLB_FULL_MASK = 4'hF.
- One sub-module: glb_read_skid, a 2-entry FIFO with push/pop, count, and full/empty flags.
- Top level holds the FSM, counters and address generation.

Test Plan:
- Load 4 words 0xA0..0xA3, base 0x100, in_valid = 1 continuous → 4 writes at 0x100/0x104/0x108/0x10C with glb_we = F each; start pulses exactly once, in the cycle after the last write.
- In RUN, hold done low for 50 cycles → glb_own = 0 throughout, start high only in the first cycle, no GLB traffic; done = 1 → DRAIN next cycle.
- Drain 8 words, base 0x400, out_ready = 1 → reads at 0x400..0x41C; out_data matches GLB contents in order; first out_valid 2 cycles after DRAIN entry; then 1 word/cycle.
- Drain with out_ready toggling 1,0,0,1 → no word dropped or duplicated; in-flight + occupancy never exceeds 2; glb_re deasserts while full.
- load_len = 0 and drain_len = 0 → IDLE→RUN→IDLE; start pulses once; zero GLB accesses; cfg_ready returns 1.
- Assert rst low mid-DRAIN after 3 of 8 words → all outputs at their reset values immediately; a new descriptor is accepted after rst is released.

Source files
------------

// File: rtl/glb_launcher_pkg.sv
// Shared types and constants for the GLB layer launcher.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package glb_launcher_pkg;

   // Launcher phases, visited in order once per layer
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } launcher_state_e;

   // Bytes per GLB word: word index to byte address scale
   localparam int GLB_WORD_BYTES = 4;

   // All four byte lanes enabled
   localparam logic [3:0] GLB_FULL_MASK = 4'hF;

endpackage

// File: rtl/glb_read_skid.sv
// Two-entry FIFO that catches GLB read data landing one cycle after issue.
// Latency: a pushed word is visible at head_o on the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module glb_read_skid #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic [1:0]   count_o,
   output logic         full_o,
   output logic         empty_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   count_q;
   logic         pop_ok;
   logic         push_ok;

   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A pop frees a slot in the same cycle, so push-while-full is fine alongside a pop
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr_q <= ~wr_ptr_q;
         if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
      end
   end

   // Data storage needs no reset: occupancy gates every read of it
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/glb_layer_launcher.sv
// Host-facing layer sequencer: load GLB, launch accelerator, drain opsums to host.
// Latency: load writes in the accept cycle; drain gives first word 2 cycles after DRAIN entry.
// Backpressure: in_ready only in LOAD; drain reads throttle so in-flight + buffered <= 2.
import glb_launcher_pkg::*;

module glb_layer_launcher #(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_BITS = 32,
   parameter int LEN_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_valid,
   output logic                 cfg_ready,
   input  logic [ADDR_BITS-1:0] cfg_load_base,
   input  logic [LEN_BITS-1:0]  cfg_load_len,
   input  logic [ADDR_BITS-1:0] cfg_drain_base,
   input  logic [LEN_BITS-1:0]  cfg_drain_len,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_SIZE-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_SIZE-1:0] out_data,
   output logic [3:0]           glb_we,
   output logic [ADDR_BITS-1:0] glb_w_addr,
   output logic [DATA_SIZE-1:0] glb_w_data,
   output logic [3:0]           glb_re,
   output logic [ADDR_BITS-1:0] glb_r_addr,
   input  logic [DATA_SIZE-1:0] glb_r_data,
   output logic                 glb_own,
   output logic                 start,
   input  logic                 done,
   output logic                 busy
);

   launcher_state_e      state_q;
   logic [ADDR_BITS-1:0] load_base_q;
   logic [LEN_BITS-1:0]  load_len_q;
   logic [ADDR_BITS-1:0] drain_base_q;
   logic [LEN_BITS-1:0]  drain_len_q;
   logic [LEN_BITS-1:0]  load_cnt_q;
   logic [LEN_BITS-1:0]  issue_cnt_q;
   logic [LEN_BITS-1:0]  pop_cnt_q;
   logic                 start_q;
   logic                 inflight_q;

   logic                 load_fire;
   logic                 load_last;
   logic                 issue_fire;
   logic                 pop_fire;
   logic                 pop_last;
   logic [2:0]           pending;
   logic [1:0]           skid_cnt;
   logic                 skid_full;
   logic                 skid_empty;
   logic [DATA_SIZE-1:0] skid_head;

   // Status and handshake decodes straight off the state register
   assign cfg_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == LOAD);
   assign glb_own   = (state_q != RUN);
   assign start     = start_q;

   // Load path: a host word is written to the GLB in the cycle it is accepted
   assign load_fire  = in_valid && in_ready;
   assign load_last  = (load_cnt_q == load_len_q - LEN_BITS'(1));
   assign glb_we     = load_fire ? GLB_FULL_MASK : 4'h0;
   assign glb_w_addr = load_base_q + ADDR_BITS'(load_cnt_q) * ADDR_BITS'(GLB_WORD_BYTES);
   assign glb_w_data = in_data;

   // Drain path: the skid head is the host-facing word
   assign out_valid = !skid_empty;
   assign out_data  = skid_head;
   assign pop_fire  = out_valid && out_ready;
   assign pop_last  = (pop_cnt_q == drain_len_q - LEN_BITS'(1));

   // Words already owed to the skid once this cycle's pop leaves; counting the
   // pop lets a new read issue against it, which keeps 1 word/cycle streaming
   assign pending = 3'(skid_cnt) + 3'(inflight_q) - 3'(pop_fire);

   assign issue_fire = (state_q == DRAIN) && (issue_cnt_q < drain_len_q) &&
                       (pending < 3'd2) && (!skid_full || pop_fire);
   assign glb_re     = issue_fire ? GLB_FULL_MASK : 4'h0;
   assign glb_r_addr = drain_base_q + ADDR_BITS'(issue_cnt_q) * ADDR_BITS'(GLB_WORD_BYTES);

   glb_read_skid #(
      .W(DATA_SIZE)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push_i    (inflight_q),
      .push_dat_i(glb_r_data),
      .pop_i     (pop_fire),
      .head_o    (skid_head),
      .count_o   (skid_cnt),
      .full_o    (skid_full),
      .empty_o   (skid_empty)
   );

   // Layer sequencer: descriptor latch, word counters and the one-cycle start pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         load_base_q  <= '0;
         load_len_q   <= '0;
         drain_base_q <= '0;
         drain_len_q  <= '0;
         load_cnt_q   <= '0;
         issue_cnt_q  <= '0;
         pop_cnt_q    <= '0;
         start_q      <= 1'b0;
         inflight_q   <= 1'b0;
      end else begin
         start_q    <= 1'b0;
         inflight_q <= issue_fire;
         case (state_q)
            IDLE: begin
               if (cfg_valid) begin
                  load_base_q  <= cfg_load_base;
                  load_len_q   <= cfg_load_len;
                  drain_base_q <= cfg_drain_base;
                  drain_len_q  <= cfg_drain_len;
                  load_cnt_q   <= '0;
                  issue_cnt_q  <= '0;
                  pop_cnt_q    <= '0;
                  if (cfg_load_len != '0) begin
                     state_q <= LOAD;
                  end else begin
                     state_q <= RUN;
                     start_q <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (load_fire) begin
                  load_cnt_q <= load_cnt_q + LEN_BITS'(1);
                  if (load_last) begin
                     state_q <= RUN;
                     start_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               // done is honoured from the very first RUN cycle
               if (done) begin
                  state_q <= (drain_len_q == '0) ? IDLE : DRAIN;
               end
            end
            DRAIN: begin
               if (issue_fire) issue_cnt_q <= issue_cnt_q + LEN_BITS'(1);
               if (pop_fire) begin
                  pop_cnt_q <= pop_cnt_q + LEN_BITS'(1);
                  if (pop_last) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_glb_layer_launcher.sv
// Directed bench for glb_layer_launcher: load/launch/drain sequences and reset.
// Latency: n/a.
// Backpressure: drives out_ready always-on and in a 1,0,0,1 pattern.
module tb_glb_layer_launcher;

   logic        clk;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_load_base;
   logic [15:0] cfg_load_len;
   logic [31:0] cfg_drain_base;
   logic [15:0] cfg_drain_len;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  glb_we;
   logic [31:0] glb_w_addr;
   logic [31:0] glb_w_data;
   logic [3:0]  glb_re;
   logic [31:0] glb_r_addr;
   logic [31:0] glb_r_data;
   logic        glb_own;
   logic        start;
   logic        done;
   logic        busy;

   int tests;
   int fails;

   glb_layer_launcher #(
      .DATA_SIZE(32),
      .ADDR_BITS(32),
      .LEN_BITS (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_valid     (cfg_valid),
      .cfg_ready     (cfg_ready),
      .cfg_load_base (cfg_load_base),
      .cfg_load_len  (cfg_load_len),
      .cfg_drain_base(cfg_drain_base),
      .cfg_drain_len (cfg_drain_len),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .glb_we        (glb_we),
      .glb_w_addr    (glb_w_addr),
      .glb_w_data    (glb_w_data),
      .glb_re        (glb_re),
      .glb_r_addr    (glb_r_addr),
      .glb_r_data    (glb_r_data),
      .glb_own       (glb_own),
      .start         (start),
      .done          (done),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // GLB contents are a fixed function of the byte address
   function automatic logic [31:0] gmem(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   // One-cycle read latency GLB model
   always @(posedge clk) begin
      if (glb_re != 4'h0) glb_r_data <= gmem(glb_r_addr);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        cfg_v;
      logic        in_v;
      logic [31:0] in_d;
      logic        exp_cfg_rdy;
      logic        exp_in_rdy;
      logic [3:0]  exp_we;
      logic [31:0] exp_waddr;
      logic        exp_start;
      logic        exp_own;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[7];

   // Drain a layer already in DRAIN (next negedge is the first DRAIN cycle).
   // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,1.
   // stop_after > 0 returns right after that many words were popped.
   task automatic drain_run(input logic [31:0] base, input int n, input int mode,
                            input int stop_after);
      int issued;
      int popped;
      int occ;
      int infl;
      logic pop;
      logic [3:0] pat;
      issued = 0;
      popped = 0;
      occ    = 0;
      infl   = 0;
      pat    = 4'b1001;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         done      = 1'b0;
         out_ready = (mode == 0) ? 1'b1 : pat[3 - (k % 4)];
         #1;
         check("drain_we_zero", glb_we, 4'h0);
         check("drain_own", glb_own, 1'b1);
         check("drain_out_valid", out_valid, (occ != 0));
         if (occ == 2 && !out_ready) check("drain_re_off_when_full", glb_re, 4'h0);
         if (glb_re != 4'h0) begin
            check("drain_r_addr", glb_r_addr, base + 32'(issued) * 32'd4);
            issued++;
         end
         pop = out_valid && out_ready;
         if (pop) begin
            check("drain_out_data", out_data, gmem(base + 32'(popped) * 32'd4));
            if (mode == 0) check("drain_pop_cycle", k, 2 + popped);
            popped++;
         end
         check("drain_inflight_le2", (issued - popped) <= 2, 1'b1);
         occ  = occ + infl - (pop ? 1 : 0);
         infl = (glb_re != 4'h0) ? 1 : 0;
         if (stop_after > 0 && popped == stop_after) return;
         if (popped == n) break;
      end
      check("drain_word_count", popped, n);
      check("drain_issue_count", issued, n);
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      check("drain_end_cfg_ready", cfg_ready, 1'b1);
      check("drain_end_busy", busy, 1'b0);
   endtask

   // Descriptor with no load words; holds done low two RUN cycles then raises it
   task automatic launch_no_load(input logic [31:0] base, input logic [15:0] len);
      @(negedge clk);
      cfg_valid      = 1'b1;
      cfg_load_len   = 16'd0;
      cfg_drain_base = base;
      cfg_drain_len  = len;
      #1;
      check("nl_cfg_ready", cfg_ready, 1'b1);
      @(negedge clk);
      cfg_valid = 1'b0;
      #1;
      check("nl_start", start, 1'b1);
      check("nl_own", glb_own, 1'b0);
      @(negedge clk);
      #1;
      check("nl_start_low", start, 1'b0);
      @(negedge clk);
      done = 1'b1;
      #1;
      check("nl_still_run", glb_own, 1'b0);
   endtask

   initial begin
      tests          = 0;
      fails          = 0;
      rst            = 1'b0;
      cfg_valid      = 1'b0;
      cfg_load_base  = 32'h100;
      cfg_load_len   = 16'd4;
      cfg_drain_base = 32'h400;
      cfg_drain_len  = 16'd8;
      in_valid       = 1'b0;
      in_data        = 32'h0;
      out_ready      = 1'b0;
      done           = 1'b0;
      glb_r_data     = 32'h0;

      //            cfg in  data     crdy irdy we    waddr    st own busy
      vecs[0] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h0,   1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'hA0, 1'b0, 1'b1, 4'hF, 32'h100, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 1'b1, 32'hA1, 1'b0, 1'b1, 4'hF, 32'h104, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{1'b0, 1'b1, 32'hA2, 1'b0, 1'b1, 4'hF, 32'h108, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 32'hA3, 1'b0, 1'b1, 4'hF, 32'h10C, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 32'hBAD, 1'b0, 1'b0, 4'h0, 32'h0,  1'b1, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 1'b0, 1'b1};

      // Reset values
      #12;
      check("rst_cfg_ready", cfg_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_own", glb_own, 1'b1);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_we", glb_we, 4'h0);
      check("rst_re", glb_re, 4'h0);
      check("rst_start", start, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // Layer 1: load four words, then launch
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         cfg_valid = vecs[i].cfg_v;
         in_valid  = vecs[i].in_v;
         in_data   = vecs[i].in_d;
         #1;
         check("vec_cfg_ready", cfg_ready, vecs[i].exp_cfg_rdy);
         check("vec_in_ready", in_ready, vecs[i].exp_in_rdy);
         check("vec_we", glb_we, vecs[i].exp_we);
         check("vec_re", glb_re, 4'h0);
         check("vec_start", start, vecs[i].exp_start);
         check("vec_own", glb_own, vecs[i].exp_own);
         check("vec_busy", busy, vecs[i].exp_busy);
         if (vecs[i].exp_we != 4'h0) begin
            check("vec_waddr", glb_w_addr, vecs[i].exp_waddr);
            check("vec_wdata", glb_w_data, vecs[i].in_d);
         end
      end

      // Long RUN with done low: accelerator owns the GLB, no traffic, no restart
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         check("run_own", glb_own, 1'b0);
         check("run_start", start, 1'b0);
         check("run_we", glb_we, 4'h0);
         check("run_re", glb_re, 4'h0);
      end
      @(negedge clk);
      done = 1'b1;
      #1;
      check("run_done_cycle_own", glb_own, 1'b0);
      drain_run(32'h400, 8, 0, 0);

      // Zero-length layer: IDLE -> RUN -> IDLE, done in the start cycle
      @(negedge clk);
      cfg_valid     = 1'b1;
      cfg_load_len  = 16'd0;
      cfg_drain_len = 16'd0;
      #1;
      check("z_cfg_ready", cfg_ready, 1'b1);
      @(negedge clk);
      cfg_valid = 1'b0;
      done      = 1'b1;
      #1;
      check("z_start", start, 1'b1);
      check("z_own", glb_own, 1'b0);
      check("z_we", glb_we, 4'h0);
      check("z_re", glb_re, 4'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("z_idle_cfg_ready", cfg_ready, 1'b1);
         check("z_idle_busy", busy, 1'b0);
         check("z_idle_start", start, 1'b0);
         check("z_idle_re", glb_re, 4'h0);
      end
      @(negedge clk);
      done = 1'b0;

      // Drain under out_ready pattern 1,0,0,1
      launch_no_load(32'h800, 16'd8);
      drain_run(32'h800, 8, 1, 0);

      // Reset in the middle of a drain
      launch_no_load(32'h400, 16'd8);
      drain_run(32'h400, 8, 0, 3);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_cfg_ready", cfg_ready, 1'b1);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_own", glb_own, 1'b1);
      check("mid_rst_re", glb_re, 4'h0);
      check("mid_rst_we", glb_we, 4'h0);
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_start", start, 1'b0);
      check("mid_rst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      rst       = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      cfg_valid     = 1'b1;
      cfg_load_base = 32'h200;
      cfg_load_len  = 16'd2;
      #1;
      check("post_rst_cfg_ready", cfg_ready, 1'b1);
      @(negedge clk);
      cfg_valid = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h55;
      #1;
      check("post_rst_in_ready", in_ready, 1'b1);
      check("post_rst_waddr", glb_w_addr, 32'h200);
      check("post_rst_we", glb_we, 4'hF);
      @(negedge clk);
      in_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
